// File: rtl/mult_sched.sv
// Two-requester front end for one shared pipelined 11x8 signed multiplier.
// Round-robin issue with per-requester credit; products return in issue order.
module mult_sched #(
    parameter int LATENCY   = 7,
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [10:0] req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [10:0] req1_a,
    input  logic [7:0]  req1_b,
    output logic [10:0] mul_n1,
    output logic [7:0]  mul_n2,
    input  logic [18:0] mul_result,
    output logic        rsp0_valid,
    output logic [18:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [18:0] rsp1_data,
    output logic        busy
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    logic [LATENCY-1:0] tag_vld;
    logic [LATENCY-1:0] tag_id;
    logic               cap_vld;
    logic               cap_id;
    logic [CW-1:0]      cnt0;
    logic [CW-1:0]      cnt1;
    logic               rr;

    logic               elig0;
    logic               elig1;
    logic               gnt1;
    logic               acc0;
    logic               acc1;
    logic               accept;
    logic [LATENCY:0]   vld_sh;
    logic [LATENCY:0]   id_sh;

    // A response pulse frees its slot in the same cycle, so a full requester
    // may re-issue while its count is held at the limit.
    always_comb begin
        elig0  = rst_n && req0_valid && ((cnt0 < MAX_CNT) || rsp0_valid);
        elig1  = rst_n && req1_valid && ((cnt1 < MAX_CNT) || rsp1_valid);
        gnt1   = elig1 && (!elig0 || rr);
        acc0   = elig0 && !gnt1;
        acc1   = elig1 && gnt1;
        accept = acc0 || acc1;
        vld_sh = {tag_vld, accept};
        id_sh  = {tag_id, gnt1};
    end

    assign req0_ready = acc0;
    assign req1_ready = acc1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= 1'b0;
            mul_n1 <= '0;
            mul_n2 <= '0;
        end else if (accept) begin
            rr     <= !gnt1;
            mul_n1 <= gnt1 ? req1_a : req0_a;
            mul_n2 <= gnt1 ? req1_b : req0_b;
        end
    end

    // The tag leaving the last stage waits one more edge in cap_* so that it
    // lines up with the product the multiplier presents for that issue slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
            cap_vld <= 1'b0;
            cap_id  <= 1'b0;
        end else begin
            tag_vld <= vld_sh[LATENCY-1:0];
            tag_id  <= id_sh[LATENCY-1:0];
            cap_vld <= vld_sh[LATENCY];
            cap_id  <= id_sh[LATENCY];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= cap_vld && !cap_id;
            rsp1_valid <= cap_vld && cap_id;
            if (cap_vld && !cap_id) begin
                rsp0_data <= mul_result;
            end
            if (cap_vld && cap_id) begin
                rsp1_data <= mul_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            case ({acc0, rsp0_valid})
                2'b10:   cnt0 <= cnt0 + CW'(1);
                2'b01:   cnt0 <= cnt0 - CW'(1);
                default: cnt0 <= cnt0;
            endcase
            case ({acc1, rsp1_valid})
                2'b10:   cnt1 <= cnt1 + CW'(1);
                2'b01:   cnt1 <= cnt1 - CW'(1);
                default: cnt1 <= cnt1;
            endcase
        end
    end

    assign busy = (|tag_vld) || cap_vld || rsp0_valid || rsp1_valid;

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: issue side pushes expected responses,
// a negedge monitor pops and compares id, product and arrival cycle.
module tb_mult_sched;

    localparam int LAT  = 7;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [10:0] req0_a, req1_a;
    logic [7:0]  req0_b, req1_b;
    logic [10:0] mul_n1;
    logic [7:0]  mul_n2;
    logic [18:0] mul_result;
    logic        rsp0_valid, rsp1_valid;
    logic [18:0] rsp0_data, rsp1_data;
    logic        busy;

    always #5 clk = ~clk;

    mult_sched #(.LATENCY(LAT), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_n1(mul_n1), .mul_n2(mul_n2), .mul_result(mul_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    // External multiplier: operands sampled each edge, product LAT edges later.
    logic [LAT*19-1:0] mp = '0;
    logic [18:0]       prod_now;
    assign prod_now   = {{8{mul_n1[10]}}, mul_n1} * {{11{mul_n2[7]}}, mul_n2};
    assign mul_result = mp[LAT*19-1 -: 19];
    always @(posedge clk) mp <= {mp[(LAT-1)*19-1:0], prod_now};

    typedef struct { logic [10:0] a; logic [7:0] b; logic [18:0] p; } op_t;
    typedef struct { logic id; logic [18:0] p; int unsigned due; } exp_t;

    op_t         vec [10];
    op_t         pend0[$], pend1[$];
    exp_t        sb[$];
    logic        acc_id[$];
    int unsigned acc_cyc[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        en0 = 1'b1, en1 = 1'b1, rnd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_exclusive", 32'(rsp0_valid && rsp1_valid), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
                chk("rsp_data", 32'(rsp1_valid ? rsp1_data : rsp0_data), 32'(e.p));
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic drive();
        req0_valid = en0 && (pend0.size() != 0);
        req1_valid = en1 && (pend1.size() != 0);
        if (pend0.size() != 0) begin
            req0_a = pend0[0].a;
            req0_b = pend0[0].b;
        end
        if (pend1.size() != 0) begin
            req1_a = pend1[0].a;
            req1_b = pend1[0].b;
        end
    endtask

    task automatic step();
        logic a0, a1;
        logic [10:0] la;
        logic [7:0]  lb;
        la = '0;
        lb = '0;
        @(negedge clk);
        a0 = rst_n && req0_valid && req0_ready;
        a1 = rst_n && req1_valid && req1_ready;
        if (a0 || a1) chk("single_grant", 32'(a0 && a1), 32'd0);
        if (a0) begin
            sb.push_back('{1'b0, pend0[0].p, cyc + LAT + 2});
            la = pend0[0].a; lb = pend0[0].b;
            acc_id.push_back(1'b0); acc_cyc.push_back(cyc);
            void'(pend0.pop_front());
        end else if (a1) begin
            sb.push_back('{1'b1, pend1[0].p, cyc + LAT + 2});
            la = pend1[0].a; lb = pend1[0].b;
            acc_id.push_back(1'b1); acc_cyc.push_back(cyc);
            void'(pend1.pop_front());
        end
        @(posedge clk);
        #1;
        if (a0 || a1) begin
            chk("mul_n1", 32'(mul_n1), 32'(la));
            chk("mul_n2", 32'(mul_n2), 32'(lb));
        end
        if (rnd) begin
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 3) != 0);
        end else begin
            en0 = 1'b1;
            en1 = 1'b1;
        end
        drive();
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_done", 32'(pend0.size() + pend1.size() + sb.size()), 32'd0);
        repeat (2) step();
    endtask

    task automatic clear_log();
        acc_id.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int unsigned rel_cyc;
        op_t o;
        vec[0] = '{11'h7FD, 8'h05, 19'h7FFF1};
        vec[1] = '{11'h400, 8'h80, 19'h20000};
        vec[2] = '{11'h3FF, 8'h7F, 19'h1FB81};
        vec[3] = '{11'h000, 8'h80, 19'h00000};
        vec[4] = '{11'h007, 8'h03, 19'h00015};
        vec[5] = '{11'h7FF, 8'h01, 19'h7FFFF};
        vec[6] = '{11'h064, 8'hFE, 19'h7FF38};
        vec[7] = '{11'h7CE, 8'hCE, 19'h009C4};
        vec[8] = '{11'h001, 8'h80, 19'h7FF80};
        vec[9] = '{11'h200, 8'h40, 19'h08000};

        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_mul_n1", 32'(mul_n1), 32'd0);
        chk("rst_mul_n2", 32'(mul_n2), 32'd0);
        chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        chk("rst_rsp_data", 32'(rsp0_data | rsp1_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel_cyc = cyc;

        // single operation, issued in the first cycle after reset release
        clear_log();
        pend0.push_back(vec[0]);
        drive();
        drain(60);
        if (acc_cyc.size() != 0) chk("first_accept_cycle", acc_cyc[0], rel_cyc);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("rsp0_data_hold", 32'(rsp0_data), 32'h7FFF1);

        // corner products
        for (int i = 1; i <= 3; i++) pend0.push_back(vec[i]);
        drive();
        drain(60);

        // reset while three operations are in flight
        clear_log();
        for (int i = 1; i <= 3; i++) pend0.push_back(vec[i]);
        drive();
        repeat (3) step();
        chk("midrst_accepts", 32'(acc_cyc.size()), 32'd3);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mul_n1", 32'(mul_n1), 32'd0);
        chk("midrst_rsp0_data", 32'(rsp0_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 6) step();
        chk("midrst_busy_after", 32'(busy), 32'd0);

        // contention: strict alternation from requester 0, then credit stall
        clear_log();
        for (int i = 0; i < 5; i++) pend0.push_back(vec[i]);
        for (int i = 5; i < 10; i++) pend1.push_back(vec[i]);
        drive();
        drain(100);
        chk("cont_accepts", 32'(acc_id.size()), 32'd10);
        if (acc_id.size() == 10) begin
            for (int i = 0; i < 10; i++) chk("cont_grant_order", 32'(acc_id[i]), 32'(i % 2));
            chk("cont_b2b", acc_cyc[7] - acc_cyc[0], 32'd7);
            chk("cont_reissue0", acc_cyc[8] - acc_cyc[0], 32'(LAT + 2));
            chk("cont_reissue1", acc_cyc[9] - acc_cyc[1], 32'(LAT + 2));
        end

        // credit limit on a single requester
        clear_log();
        for (int i = 4; i < 10; i++) pend1.push_back(vec[i]);
        drive();
        drain(100);
        chk("credit_accepts", 32'(acc_cyc.size()), 32'd6);
        if (acc_cyc.size() == 6) begin
            chk("credit_b2b", acc_cyc[3] - acc_cyc[0], 32'd3);
            chk("credit_reissue0", acc_cyc[4] - acc_cyc[0], 32'(LAT + 2));
            chk("credit_reissue1", acc_cyc[5] - acc_cyc[1], 32'(LAT + 2));
        end

        // random operands and valid duty
        clear_log();
        for (int i = 0; i < 300; i++) begin
            o.a = 11'($urandom);
            o.b = 8'($urandom);
            o.p = {{8{o.a[10]}}, o.a} * {{11{o.b[7]}}, o.b};
            if ($urandom_range(0, 1) == 0) pend0.push_back(o);
            else pend1.push_back(o);
        end
        rnd = 1'b1;
        drive();
        drain(4000);
        rnd = 1'b0;
        chk("rand_accepts", 32'(acc_cyc.size()), 32'd300);
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
